// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV32M multiply/divide unit.
// Operand magnitudes are latched when a request is accepted. The unit then
// runs 32 shift-add (multiply) or restoring shift-subtract (divide) steps,
// one FIX cycle for the sign correction, and holds the result in DONE until
// write-back takes it. Divide-by-zero and signed overflow skip the
// iterations and produce their architectural results one cycle after accept.
module muldiv_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [4:0]      i_rd_addr,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_wb_ready,
    output logic [4:0]      o_rd_addr,
    output logic [XLEN-1:0] o_rd_data,
    output logic            o_rd_wren
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    logic [1:0]        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        funct3_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   opb_q;        // multiplicand (multiply) or divisor (divide)
    logic [2*XLEN-1:0] acc_q;        // {hi, lo}: product, or {remainder, dividend/quotient}
    logic              a_neg_q;      // rs1 was negative (remainder sign)
    logic              res_neg_q;    // product / quotient sign
    logic              special_q;    // result already placed in o_rd_data at accept
    logic [XLEN-1:0]   rd_data_q;

    // Accept-time decode
    logic              accept;
    logic              op_div;
    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   special_val;

    // Iteration step and sign fix-up
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_trial;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_result;

    assign o_ready   = (state_q == S_IDLE);
    assign o_valid   = (state_q == S_DONE);
    assign o_rd_addr = rd_q;
    assign o_rd_data = rd_data_q;
    assign o_rd_wren = o_valid && (rd_q != 5'd0);

    // A flush in IDLE suppresses the concurrent request.
    assign accept = i_valid && o_ready && !i_flush;

    // Decode operand signedness and the special divide cases from live inputs
    always_comb begin
        // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
        op_div      = i_funct3[2];
        a_signed    = op_div ? !i_funct3[0] : (i_funct3[1:0] != 2'd3);
        b_signed    = op_div ? !i_funct3[0] : !i_funct3[1];
        a_neg       = a_signed && i_rs1_data[XLEN-1];
        b_neg       = b_signed && i_rs2_data[XLEN-1];
        a_mag       = a_neg ? -i_rs1_data : i_rs1_data;
        b_mag       = b_neg ? -i_rs2_data : i_rs2_data;
        div_zero    = op_div && (i_rs2_data == '0);
        div_ovf     = op_div && !i_funct3[0] &&
                      (i_rs1_data == INT_MIN) && (i_rs2_data == ALL_ONES);
        special_val = '0;
        if (div_zero)
            special_val = i_funct3[1] ? i_rs1_data : ALL_ONES;
        else if (div_ovf)
            special_val = i_funct3[1] ? '0 : INT_MIN;
    end

    // One multiply step (add then shift right) and one restoring divide step
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_trial = acc_q[2*XLEN-1:XLEN-1];
        // When the trial subtraction succeeds the difference is below the
        // divisor, so the low XLEN bits are exact.
        div_diff  = div_trial[XLEN-1:0] - opb_q;
        if (div_trial >= {1'b0, opb_q})
            div_next = {div_diff, acc_q[XLEN-2:0], 1'b1};
        else
            div_next = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end

    // Sign correction and result selection used in the FIX cycle
    always_comb begin
        prod_fix = res_neg_q ? -acc_q : acc_q;
        quot_fix = res_neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = a_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        if (funct3_q[2])
            fix_result = funct3_q[1] ? rem_fix : quot_fix;
        else if (funct3_q[1:0] == 2'd0)
            fix_result = prod_fix[XLEN-1:0];
        else
            fix_result = prod_fix[2*XLEN-1:XLEN];
    end

    // Control FSM and datapath registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (i_reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            funct3_q  <= '0;
            rd_q      <= '0;
            opb_q     <= '0;
            acc_q     <= '0;
            a_neg_q   <= 1'b0;
            res_neg_q <= 1'b0;
            special_q <= 1'b0;
            rd_data_q <= '0;
        end else if (i_flush) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        funct3_q  <= i_funct3;
                        rd_q      <= i_rd_addr;
                        a_neg_q   <= a_neg;
                        res_neg_q <= a_neg ^ b_neg;
                        cnt_q     <= '0;
                        opb_q     <= op_div ? b_mag : a_mag;
                        acc_q     <= {{XLEN{1'b0}}, (op_div ? a_mag : b_mag)};
                        special_q <= div_zero || div_ovf;
                        if (div_zero || div_ovf) begin
                            rd_data_q <= special_val;
                            state_q   <= S_FIX;
                        end else begin
                            state_q   <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= funct3_q[2] ? div_next : mul_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER)
                        state_q <= S_FIX;
                end
                S_FIX: begin
                    if (!special_q)
                        rd_data_q <= fix_result;
                    state_q <= S_DONE;
                end
                default: begin
                    if (i_wb_ready)
                        state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed self-checking bench for muldiv_iter.
// Expected values are hand-computed RV32M results.
module tb_muldiv_iter;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [2:0]  i_funct3 = '0;
    logic [31:0] i_rs1_data = '0;
    logic [31:0] i_rs2_data = '0;
    logic [4:0]  i_rd_addr = '0;
    logic        i_flush = 1'b0;
    logic        o_valid;
    logic        i_wb_ready = 1'b0;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    logic        o_rd_wren;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
    localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;

    muldiv_iter #(.XLEN(32), .CNT_W(6)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_funct3   (i_funct3),
        .i_rs1_data (i_rs1_data),
        .i_rs2_data (i_rs2_data),
        .i_rd_addr  (i_rd_addr),
        .i_flush    (i_flush),
        .o_valid    (o_valid),
        .i_wb_ready (i_wb_ready),
        .o_rd_addr  (o_rd_addr),
        .o_rd_data  (o_rd_data),
        .o_rd_wren  (o_rd_wren)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge, then scramble the operand inputs.
    task automatic start_op(input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd);
        @(negedge i_clk);
        i_funct3   = f3;
        i_rs1_data = a;
        i_rs2_data = b;
        i_rd_addr  = rd;
        i_valid    = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid    = 1'b0;
        i_rs1_data = $urandom;
        i_rs2_data = $urandom;
        i_funct3   = 3'($urandom);
        i_rd_addr  = 5'($urandom);
    endtask

    // Count edges after the accept edge until o_valid; 0 means timed out.
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge i_clk);
            #1;
            if (o_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat, input int hold);
        int lat;
        start_op(f3, a, b, rd);
        wait_valid(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, o_rd_data, exp);
        check({tag, "_addr"}, 32'(o_rd_addr), 32'(rd));
        check({tag, "_wren"}, 32'(o_rd_wren), 32'(rd != 5'd0));
        check({tag, "_busy"}, 32'(o_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge i_clk);
            #1;
            check({tag, "_hold_valid"}, 32'(o_valid), 32'd1);
            check({tag, "_hold_data"}, o_rd_data, exp);
            check({tag, "_hold_ready"}, 32'(o_ready), 32'd0);
        end
        i_wb_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_wb_ready = 1'b0;
        check({tag, "_after_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_after_ready"}, 32'(o_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int seen;

        // Reset state
        #1;
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_wren",  32'(o_rd_wren), 32'd0);
        check("rst_addr",  32'(o_rd_addr), 32'd0);
        check("rst_data",  o_rd_data, 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;

        // Multiply family
        run_op("mul_7x-3",   F_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33, 0);
        run_op("mulh_min",   F_MULH,   32'h8000_0000, 32'hFFFF_FFFF, 5'd6,  32'h0000_0000, 33, 0);
        run_op("mulhsu_min", F_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7,  32'h8000_0000, 33, 0);
        run_op("mulhu_min",  F_MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'h7FFF_FFFF, 33, 0);
        run_op("mul_min",    F_MUL,    32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h8000_0000, 33, 0);

        // Divide family
        run_op("div_-7_2",   F_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFD, 33, 0);
        run_op("rem_-7_2",   F_REM,    32'hFFFF_FFF9, 32'h0000_0002, 5'd11, 32'hFFFF_FFFF, 33, 0);
        run_op("divu_100_7", F_DIVU,   32'd100,       32'd7,         5'd12, 32'd14,        33, 5);
        run_op("remu_100_7", F_REMU,   32'd100,       32'd7,         5'd13, 32'd2,         33, 0);

        // Special cases
        run_op("div_zero",   F_DIV,    32'h1234_5678, 32'h0000_0000, 5'd14, 32'hFFFF_FFFF, 1, 0);
        run_op("remu_zero",  F_REMU,   32'h1234_5678, 32'h0000_0000, 5'd15, 32'h1234_5678, 1, 0);
        run_op("div_ovf",    F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1, 0);
        run_op("rem_ovf",    F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0000_0000, 1, 0);

        // Destination x0: runs fully, write enable stays low
        run_op("mul_x0",     F_MUL,    32'd6,         32'd7,         5'd0,  32'd42,        33, 0);

        // Flush together with a request in IDLE: request is ignored
        @(negedge i_clk);
        i_funct3 = F_MUL; i_rs1_data = 32'd3; i_rs2_data = 32'd3; i_rd_addr = 5'd1;
        i_valid = 1'b1;
        i_flush = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_flush = 1'b0;
        check("flush_idle_ready", 32'(o_ready), 32'd1);

        // Flush in CALC: back to IDLE, no result ever appears
        start_op(F_MULHU, 32'hFFFF_FFFF, 32'h0000_0003, 5'd3);
        repeat (10) @(posedge i_clk);
        #1;
        check("flush_calc_busy", 32'(o_ready), 32'd0);
        i_flush = 1'b1;
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        check("flush_calc_ready", 32'(o_ready), 32'd1);
        check("flush_calc_valid", 32'(o_valid), 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge i_clk);
            #1;
            if (o_valid) seen++;
        end
        check("flush_calc_no_valid", 32'(seen), 32'd0);

        // Flush in DONE with write-back ready: flush wins, result dropped
        start_op(F_DIVU, 32'd50, 32'd5, 5'd4);
        wait_valid(lat);
        check("flush_done_lat", 32'(lat), 32'd33);
        i_flush = 1'b1;
        i_wb_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        i_wb_ready = 1'b0;
        check("flush_done_valid", 32'(o_valid), 32'd0);
        check("flush_done_wren", 32'(o_rd_wren), 32'd0);
        check("flush_done_ready", 32'(o_ready), 32'd1);

        // Asynchronous reset mid-CALC, applied between edges
        start_op(F_MUL, 32'd1000, 32'd1000, 5'd9);
        repeat (5) @(posedge i_clk);
        #2;
        i_reset = 1'b1;
        #1;
        check("async_rst_ready", 32'(o_ready), 32'd1);
        check("async_rst_valid", 32'(o_valid), 32'd0);
        check("async_rst_wren",  32'(o_rd_wren), 32'd0);
        check("async_rst_addr",  32'(o_rd_addr), 32'd0);
        check("async_rst_data",  o_rd_data, 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;

        run_op("mulhu_max", F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFE, 33, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
